// File: rtl/afifo_rd_skid_47bit_if.sv
// Read-side bundle of the 47-bit CDC FIFO consumer: FIFO pop port plus the downstream request bus.
// AFIFO_RD_SKID_STAT_EN adds the beat/stall statistic counters to the bundle.
interface afifo_rd_skid_47bit_if;
    logic        rempty;
    logic [46:0] rdata;
    logic        rpop;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [7:0]  m_id;
    logic [3:0]  m_len;
    logic [2:0]  m_size;
    logic [46:0] m_raw;
    logic [1:0]  occ;
`ifdef AFIFO_RD_SKID_STAT_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
`endif

    // master: the skid consumer; slave: the FIFO plus downstream sink around it
    modport master (
        input  rempty, rdata, m_ready,
        output rpop, m_valid, m_addr, m_id, m_len, m_size, m_raw, occ
`ifdef AFIFO_RD_SKID_STAT_EN
        , output beat_cnt, stall_cnt
`endif
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rpop, m_valid, m_addr, m_id, m_len, m_size, m_raw, occ
`ifdef AFIFO_RD_SKID_STAT_EN
        , input beat_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/afifo_rd_skid_47bit.sv
// Read-domain consumer of the 47-bit async FIFO: pops into a 2-entry skid buffer, presents a registered valid/ready request.
// Define AFIFO_RD_SKID_STAT_EN to add beat_cnt (wrapping) and stall_cnt (saturating) statistics.
module afifo_rd_skid_47bit #(
    parameter int DEPTH = 2,
    parameter int DW    = 47
) (
    input  logic                   rclk,
    input  logic                   rrst,
    afifo_rd_skid_47bit_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;
    logic          deq;

    // Pop only from registered state and rempty, keeping m_ready off the FIFO timing path.
    assign pop = !bus.rempty && (cnt_q != FULL) && !rrst;
    assign deq = (cnt_q != '0) && bus.m_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + CW'(pop) - CW'(deq);
        if (deq && (cnt_q == FULL)) begin
            head_d = tail_q;
        end
        if (pop) begin
            // The new entry lands in the head whenever the head is vacated this cycle.
            if ((cnt_q == '0) || ((cnt_q == CW'(1)) && deq)) begin
                head_d = bus.rdata;
            end else begin
                tail_d = bus.rdata;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.rpop    = pop;
    assign bus.m_valid = (cnt_q != '0);
    assign bus.m_raw   = head_q;
    assign bus.m_addr  = head_q[46:15];
    assign bus.m_id    = head_q[14:7];
    assign bus.m_len   = head_q[6:3];
    assign bus.m_size  = head_q[2:0];
    assign bus.occ     = cnt_q;

`ifdef AFIFO_RD_SKID_STAT_EN
    logic [15:0] beat_q, beat_d;
    logic [15:0] stall_q, stall_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        beat_d  = deq ? beat_q + 16'd1 : beat_q;
        stall_d = ((cnt_q != '0) && !bus.m_ready) ? sat_inc16(stall_q) : stall_q;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    assign bus.beat_cnt  = beat_q;
    assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_afifo_rd_skid_47bit.sv
// Bench for afifo_rd_skid_47bit: a queue-based FIFO and skid model predicts pops, occupancy and the head entry.
module tb_afifo_rd_skid_47bit;
    logic rclk = 1'b0;
    logic rrst = 1'b1;
    always #5 rclk = ~rclk;

    afifo_rd_skid_47bit_if bus();
    afifo_rd_skid_47bit dut (.rclk(rclk), .rrst(rrst), .bus(bus));

    logic [46:0] fifo[$];
    logic [46:0] skid[$];
    logic [46:0] got[$];
    logic [46:0] sent[$];
    int tests = 0;
    int fails = 0;
    int beats_m = 0;
    int stalls_m = 0;

    function automatic logic [46:0] rnd47();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[46:0];
    endfunction

    // Advance one clock: model the FIFO and skid queue as the DUT should see this edge.
    task automatic tick();
        bit p, d;
        @(posedge rclk);
        p = !rrst && fifo.size() != 0 && skid.size() < 2;
        d = !rrst && skid.size() != 0 && bus.m_ready;
        if (!rrst && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got.push_back(bus.m_raw);
        if (rrst) begin
            skid.delete();
            beats_m = 0;
            stalls_m = 0;
        end else begin
            if (skid.size() != 0 && !bus.m_ready && stalls_m < 65535) stalls_m++;
            if (d) begin
                void'(skid.pop_front());
                beats_m = (beats_m + 1) % 65536;
            end
            if (p) skid.push_back(fifo.pop_front());
        end
        #1;
        bus.rempty = (fifo.size() == 0);
        bus.rdata  = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push(input logic [46:0] v);
        fifo.push_back(v);
        sent.push_back(v);
        bus.rempty = 1'b0;
        bus.rdata  = fifo[0];
    endtask

    task automatic test_reset();
        logic e_rpop;
        rrst = 1'b1;
        bus.m_ready = 1'b1;
        push(rnd47());
        push(rnd47());
        repeat (2) tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge rclk);
            tests += 4;
            if (bus.rpop !== 1'b0) begin fails++; $display("FAIL reset_rpop cyc %0d: got %b want 0", c, bus.rpop); end
            if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc %0d: got %b want 0", c, bus.m_valid); end
            if (bus.occ !== 2'd0) begin fails++; $display("FAIL reset_occ cyc %0d: got %0d want 0", c, bus.occ); end
            if (bus.m_raw !== 47'd0) begin fails++; $display("FAIL reset_raw cyc %0d: got %h want 0", c, bus.m_raw); end
            tick();
        end
        rrst = 1'b0;
        @(negedge rclk);
        tests++;
        if (bus.rpop !== 1'b1) begin fails++; $display("FAIL first_rpop: got %b want 1", bus.rpop); end
        tick();
        @(negedge rclk);
        tests++;
        if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b want 1", bus.m_valid); end
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            e_rpop = !rrst && fifo.size() != 0 && skid.size() < 2;
            tests += 2;
            if (bus.rpop !== e_rpop) begin fails++; $display("FAIL reset_drain_rpop cyc %0d: got %b want %b", c, bus.rpop, e_rpop); end
            if (bus.occ !== 2'(skid.size())) begin fails++; $display("FAIL reset_drain_occ cyc %0d: got %0d want %0d", c, bus.occ, skid.size()); end
            tick();
        end
    endtask

    task automatic test_single();
        bus.m_ready = 1'b1;
        // Entry packed from addr A2468ACF, id F5, len 9, size 5.
        push(47'h5123_4567_FACD);
        @(negedge rclk);
        tests += 2;
        if (bus.rpop !== 1'b1) begin fails++; $display("FAIL single_rpop: got %b want 1", bus.rpop); end
        if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", bus.m_valid); end
        tick();
        @(negedge rclk);
        tests += 6;
        if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bus.m_valid); end
        if (bus.m_addr !== 32'hA2468ACF) begin fails++; $display("FAIL single_addr: got %h want a2468acf", bus.m_addr); end
        if (bus.m_id !== 8'hF5) begin fails++; $display("FAIL single_id: got %h want f5", bus.m_id); end
        if (bus.m_len !== 4'h9) begin fails++; $display("FAIL single_len: got %h want 9", bus.m_len); end
        if (bus.m_size !== 3'h5) begin fails++; $display("FAIL single_size: got %h want 5", bus.m_size); end
        if (bus.occ !== 2'd1) begin fails++; $display("FAIL single_occ1: got %0d want 1", bus.occ); end
        tick();
        @(negedge rclk);
        tests += 2;
        if (bus.occ !== 2'd0) begin fails++; $display("FAIL single_occ0: got %0d want 0", bus.occ); end
        if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL single_done_valid: got %b want 0", bus.m_valid); end
        tick();
    endtask

    task automatic test_stream();
        logic e_rpop;
        int npop = 0;
        int first = -1;
        int last = -1;
        got.delete();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(47'(i));
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            e_rpop = !rrst && fifo.size() != 0 && skid.size() < 2;
            tests += 3;
            if (bus.rpop !== e_rpop) begin fails++; $display("FAIL stream_rpop cyc %0d: got %b want %b", c, bus.rpop, e_rpop); end
            if (bus.occ !== 2'(skid.size())) begin fails++; $display("FAIL stream_occ cyc %0d: got %0d want %0d", c, bus.occ, skid.size()); end
            if (bus.m_valid !== (skid.size() != 0)) begin fails++; $display("FAIL stream_valid cyc %0d: got %b", c, bus.m_valid); end
            if (bus.rpop === 1'b1) begin
                npop++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        tests += 2;
        if (npop != 16 || last - first != 15) begin fails++; $display("FAIL stream_pops: got %0d pops over %0d cycles want 16 over 16", npop, last - first + 1); end
        if (got.size() != 16) begin fails++; $display("FAIL stream_count: got %0d want 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 47'(i)) begin fails++; $display("FAIL stream_order idx %0d: got %h want %h", i, got[i], i); end
        end
    endtask

    task automatic test_stall();
        logic e_rpop;
        logic [46:0] e[5];
        got.delete();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e[i] = rnd47();
            push(e[i]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            e_rpop = !rrst && fifo.size() != 0 && skid.size() < 2;
            tests += 2;
            if (bus.rpop !== e_rpop) begin fails++; $display("FAIL stall_rpop cyc %0d: got %b want %b", c, bus.rpop, e_rpop); end
            if (skid.size() != 0) begin
                if (bus.m_raw !== e[0]) begin fails++; $display("FAIL stall_head cyc %0d: got %h want %h", c, bus.m_raw, e[0]); end
            end else if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL stall_valid cyc %0d: got %b want 0", c, bus.m_valid); end
            tick();
        end
        @(negedge rclk);
        tests += 3;
        if (bus.occ !== 2'd2) begin fails++; $display("FAIL stall_full_occ: got %0d want 2", bus.occ); end
        if (bus.rpop !== 1'b0) begin fails++; $display("FAIL stall_full_rpop: got %b want 0", bus.rpop); end
        if (bus.m_raw !== e[0]) begin fails++; $display("FAIL stall_full_head: got %h want %h", bus.m_raw, e[0]); end
        tick();
        bus.m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk);
            e_rpop = !rrst && fifo.size() != 0 && skid.size() < 2;
            tests += 2;
            if (bus.rpop !== e_rpop) begin fails++; $display("FAIL release_rpop cyc %0d: got %b want %b", c, bus.rpop, e_rpop); end
            if (bus.occ !== 2'(skid.size())) begin fails++; $display("FAIL release_occ cyc %0d: got %0d want %0d", c, bus.occ, skid.size()); end
            tick();
        end
        tests++;
        if (got.size() != 5) begin fails++; $display("FAIL stall_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== e[i]) begin fails++; $display("FAIL stall_order idx %0d: got %h want %h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic e_rpop;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(rnd47());
        repeat (4) tick();
        @(negedge rclk);
        tests++;
        if (bus.occ !== 2'd2) begin fails++; $display("FAIL rmid_pre_occ: got %0d want 2", bus.occ); end
        tick();
        rrst = 1'b1;
        @(negedge rclk);
        tests++;
        if (bus.rpop !== 1'b0) begin fails++; $display("FAIL rmid_rpop_in_reset: got %b want 0", bus.rpop); end
        tick();
        @(negedge rclk);
        tests += 3;
        if (bus.occ !== 2'd0) begin fails++; $display("FAIL rmid_occ: got %0d want 0", bus.occ); end
        if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", bus.m_valid); end
        if (bus.rpop !== 1'b0) begin fails++; $display("FAIL rmid_rpop_hold: got %b want 0", bus.rpop); end
        tick();
        rrst = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            e_rpop = !rrst && fifo.size() != 0 && skid.size() < 2;
            tests += 2;
            if (bus.rpop !== e_rpop) begin fails++; $display("FAIL rmid_drain_rpop cyc %0d: got %b want %b", c, bus.rpop, e_rpop); end
            if (skid.size() != 0 && bus.m_raw !== skid[0]) begin fails++; $display("FAIL rmid_drain_head cyc %0d: got %h want %h", c, bus.m_raw, skid[0]); end
            tick();
        end
    endtask

    task automatic test_random();
        logic e_rpop;
        logic [46:0] h;
        got.delete();
        sent.delete();
        for (int c = 0; c < 320; c++) begin
            @(negedge rclk);
            e_rpop = !rrst && fifo.size() != 0 && skid.size() < 2;
            tests += 3;
            if (bus.rpop !== e_rpop) begin fails++; $display("FAIL rand_rpop cyc %0d: got %b want %b", c, bus.rpop, e_rpop); end
            if (bus.occ !== 2'(skid.size())) begin fails++; $display("FAIL rand_occ cyc %0d: got %0d want %0d", c, bus.occ, skid.size()); end
            if (bus.m_valid !== (skid.size() != 0)) begin fails++; $display("FAIL rand_valid cyc %0d: got %b", c, bus.m_valid); end
            if (skid.size() != 0) begin
                h = skid[0];
                tests++;
                if (bus.m_addr !== h[46:15] || bus.m_id !== h[14:7] || bus.m_len !== h[6:3] || bus.m_size !== h[2:0])
                    begin fails++; $display("FAIL rand_fields cyc %0d: got %h/%h/%h/%h want %h", c, bus.m_addr, bus.m_id, bus.m_len, bus.m_size, h); end
            end
            tick();
            if (c < 300) begin
                bus.m_ready = ($urandom_range(3) != 0);
                if ($urandom_range(2) != 0) push(rnd47());
            end else begin
                bus.m_ready = 1'b1;
            end
        end
        tests++;
        if (got.size() != sent.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got.size(), sent.size()); end
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            tests++;
            if (got[i] !== sent[i]) begin fails++; $display("FAIL rand_order idx %0d: got %h want %h", i, got[i], sent[i]); end
        end
    endtask

`ifdef AFIFO_RD_SKID_STAT_EN
    task automatic test_stat();
        rrst = 1'b1;
        repeat (2) tick();
        rrst = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd47());
        for (int c = 0; c < 20 && !bus.m_ready; c++) begin
            tick();
            if (stalls_m >= 4) bus.m_ready = 1'b1;
        end
        repeat (6) tick();
        @(negedge rclk);
        tests += 4;
        if (bus.beat_cnt !== 16'd3) begin fails++; $display("FAIL stat_beats: got %0d want 3", bus.beat_cnt); end
        if (bus.stall_cnt !== 16'd4) begin fails++; $display("FAIL stat_stalls: got %0d want 4", bus.stall_cnt); end
        if (bus.beat_cnt !== 16'(beats_m)) begin fails++; $display("FAIL stat_beats_model: got %0d want %0d", bus.beat_cnt, beats_m); end
        if (bus.stall_cnt !== 16'(stalls_m)) begin fails++; $display("FAIL stat_stalls_model: got %0d want %0d", bus.stall_cnt, stalls_m); end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rempty  = 1'b1;
        bus.rdata   = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef AFIFO_RD_SKID_STAT_EN
        test_stat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
